// File: rtl/llc_tag_engine_pkg.sv
// cache_define: default cache geometry, derived-width helpers, result codes and op/state encodings
package cache_define;
  localparam int DEF_ADDR_SIZE = 32;
  localparam int DEF_CACHE_SIZE = 1024;
  localparam int DEF_ASSOC = 4;
  localparam int DEF_CACHE_LINE = 64;
  function automatic int index_of(input int cache_size, input int assoc, input int line);
    return cache_size / (assoc * line);
  endfunction
  function automatic int tag_bits_of(input int addr_size, input int cache_size, input int assoc, input int line);
    return addr_size - $clog2(index_of(cache_size, assoc, line)) - $clog2(line);
  endfunction
  localparam int DEF_INDEX = index_of(DEF_CACHE_SIZE, DEF_ASSOC, DEF_CACHE_LINE);
  localparam int DEF_INDEX_BITS = $clog2(DEF_INDEX);
  localparam int DEF_BYTE_BITS = $clog2(DEF_CACHE_LINE);
  localparam int DEF_TAG_BITS = tag_bits_of(DEF_ADDR_SIZE, DEF_CACHE_SIZE, DEF_ASSOC, DEF_CACHE_LINE);
  localparam int DEF_LRU_BITS = DEF_ASSOC - 1;
  localparam logic [1:0] RES_HIT = 2'd1;
  localparam logic [1:0] RES_MISS = 2'd2;
  typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_INVALIDATE = 2'd2, OP_RESERVED = 2'd3} req_op_e;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_LOOKUP, ST_RESP} state_e;
endpackage

// File: rtl/llc_tag_engine_plru_tree.sv
// llc_plru_tree: victim choice (lowest invalid way, else tree PLRU) and tree update for an accessed way
module llc_plru_tree #(
  parameter int ASSOC = 4,
  localparam int WAY_BITS = $clog2(ASSOC)
) (
  input  logic [ASSOC-2:0]    tree,
  input  logic [ASSOC-1:0]    valid,
  input  logic [WAY_BITS-1:0] way,
  output logic [WAY_BITS-1:0] victim,
  output logic [ASSOC-2:0]    tree_next
);
  logic [WAY_BITS-1:0] plru_way, free_way, node_v, node_u;
  logic b_v, b_u;
  // walk the tree from the root following node bits (heap order, node n at bit n-1); prefer any invalid way
  always_comb begin
    node_v = WAY_BITS'(1);
    plru_way = '0;
    b_v = 1'b0;
    for (int l = 0; l < WAY_BITS; l++) begin
      b_v = tree[node_v - WAY_BITS'(1)];
      plru_way = (plru_way << 1) | WAY_BITS'(b_v);
      node_v = (node_v << 1) | WAY_BITS'(b_v);
    end
    free_way = '0;
    for (int i = ASSOC - 1; i >= 0; i--)
      if (!valid[i]) free_way = WAY_BITS'(i);
    victim = &valid ? plru_way : free_way;
  end
  // point every node on the accessed way's path toward the other half
  always_comb begin
    tree_next = tree;
    node_u = WAY_BITS'(1);
    b_u = 1'b0;
    for (int l = 0; l < WAY_BITS; l++) begin
      b_u = way[WAY_BITS-1-l];
      tree_next[node_u - WAY_BITS'(1)] = ~b_u;
      node_u = (node_u << 1) | WAY_BITS'(b_u);
    end
  end
endmodule

// File: rtl/llc_tag_engine.sv
// llc_tag_engine: set-associative tag/state engine with PLRU replacement, one request in flight
module llc_tag_engine
  import cache_define::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int CACHE_SIZE = DEF_CACHE_SIZE,
  parameter int ASSOC = DEF_ASSOC,
  parameter int CACHE_LINE = DEF_CACHE_LINE,
  localparam int INDEX = index_of(CACHE_SIZE, ASSOC, CACHE_LINE),
  localparam int INDEX_BITS = $clog2(INDEX),
  localparam int BYTE_BITS = $clog2(CACHE_LINE),
  localparam int TAG_BITS = tag_bits_of(ADDR_SIZE, CACHE_SIZE, ASSOC, CACHE_LINE),
  localparam int LRU_BITS = ASSOC - 1,
  localparam int WAY_BITS = $clog2(ASSOC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [1:0]           req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_result,
  output logic [WAY_BITS-1:0]  rsp_way,
  output logic                 rsp_evict_valid,
  output logic [TAG_BITS-1:0]  rsp_evict_tag,
  output logic                 rsp_evict_dirty,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);
  state_e state, state_next;
  req_op_e op;
  logic [INDEX_BITS-1:0] init_set, set;
  logic [ADDR_SIZE-1:BYTE_BITS] line_addr;
  logic [TAG_BITS-1:0] tag, evict_tag;
  logic [TAG_BITS-1:0] tag_mem [INDEX][ASSOC];
  logic [ASSOC-1:0] valid_mem [INDEX];
  logic [ASSOC-1:0] dirty_mem [INDEX];
  logic [LRU_BITS-1:0] lru_mem [INDEX];
  logic [ASSOC-1:0] hit_vec, cur_valid, cur_dirty;
  logic [LRU_BITS-1:0] cur_lru, lru_next;
  logic [WAY_BITS-1:0] hit_way, victim, access_way;
  logic hit, is_inv, is_write, evict_valid, evict_dirty, unused_ok;
  assign unused_ok = ^req_addr[BYTE_BITS-1:0];
  assign set = line_addr[BYTE_BITS +: INDEX_BITS];
  assign tag = line_addr[ADDR_SIZE-1 -: TAG_BITS];
  assign is_inv = op == OP_INVALIDATE;
  assign is_write = op == OP_WRITE;
  assign hit = |hit_vec;
  assign access_way = hit ? hit_way : victim;
  assign evict_valid = is_inv ? hit : !hit && cur_valid[victim];
  assign evict_tag = evict_valid ? tag_mem[set][access_way] : '0;
  assign evict_dirty = evict_valid && cur_dirty[access_way];
  // read the addressed set and compare its tags in all ways
  always_comb begin
    cur_valid = valid_mem[set];
    cur_dirty = dirty_mem[set];
    cur_lru = lru_mem[set];
    hit_way = '0;
    for (int i = 0; i < ASSOC; i++) begin
      hit_vec[i] = cur_valid[i] && tag_mem[set][i] == tag;
      if (hit_vec[i]) hit_way = WAY_BITS'(i);
    end
  end
  llc_plru_tree #(.ASSOC(ASSOC)) u_plru (
    .tree(cur_lru),
    .valid(cur_valid),
    .way(access_way),
    .victim(victim),
    .tree_next(lru_next)
  );
  // next state and handshake outputs
  always_comb begin
    state_next = state == ST_INIT ? (init_set == INDEX_BITS'(INDEX - 1) ? ST_IDLE : ST_INIT)
               : state == ST_IDLE ? (req_valid ? ST_LOOKUP : ST_IDLE)
               : state == ST_LOOKUP ? ST_RESP
               : (rsp_ready ? ST_IDLE : ST_RESP);
    req_ready = state == ST_IDLE;
    rsp_valid = state == ST_RESP;
  end
  // state register; the init sweep pointer is held at set 0 while reset is asserted
  always_ff @(posedge clk) begin
    state <= rst ? ST_INIT : state_next;
    init_set <= rst ? '0 : state == ST_INIT ? init_set + 1'b1 : init_set;
  end
  // capture the accepted request
  always_ff @(posedge clk)
    if (state == ST_IDLE && req_valid) begin
      line_addr <= req_addr[ADDR_SIZE-1:BYTE_BITS];
      op <= req_op_e'(req_op);
    end
  // valid/dirty/PLRU: cleared one set per cycle during init, updated during lookup
  always_ff @(posedge clk)
    if (state == ST_INIT) begin
      valid_mem[init_set] <= '0;
      dirty_mem[init_set] <= '0;
      lru_mem[init_set] <= '0;
    end else if (state == ST_LOOKUP && !rst) begin
      if (is_inv) begin
        if (hit) begin
          valid_mem[set][hit_way] <= 1'b0;
          dirty_mem[set][hit_way] <= 1'b0;
        end
      end else begin
        valid_mem[set][access_way] <= 1'b1;
        dirty_mem[set][access_way] <= is_write || (hit && cur_dirty[access_way]);
        lru_mem[set] <= lru_next;
      end
    end
  // tag storage only changes on a fill
  always_ff @(posedge clk)
    if (state == ST_LOOKUP && !rst && !is_inv && !hit) tag_mem[set][victim] <= tag;
  // response fields and saturating statistics, loaded once on the way into RESP
  always_ff @(posedge clk)
    if (rst) begin
      rsp_result <= '0;
      rsp_way <= '0;
      rsp_evict_valid <= 1'b0;
      rsp_evict_tag <= '0;
      rsp_evict_dirty <= 1'b0;
      hit_count <= '0;
      miss_count <= '0;
    end else if (state == ST_LOOKUP) begin
      rsp_result <= hit ? RES_HIT : RES_MISS;
      rsp_way <= is_inv && !hit ? '0 : access_way;
      rsp_evict_valid <= evict_valid;
      rsp_evict_tag <= evict_tag;
      rsp_evict_dirty <= evict_dirty;
      if (hit && ~&hit_count) hit_count <= hit_count + 32'd1;
      if (!hit && ~&miss_count) miss_count <= miss_count + 32'd1;
    end
endmodule

// File: tb/tb_llc_tag_engine.sv
// tb_llc_tag_engine: randomized and directed scoreboard bench against a behavioural cache model
module tb_llc_tag_engine;
  logic clk = 0, rst = 1, req_valid = 0, rsp_ready = 0;
  logic req_ready, rsp_valid, ev_valid, ev_dirty;
  logic [31:0] req_addr = 0, hit_count, miss_count;
  logic [1:0] req_op = 0, rsp_result, rsp_way;
  logic [23:0] ev_tag;

  llc_tag_engine dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_way(rsp_way), .rsp_evict_valid(ev_valid), .rsp_evict_tag(ev_tag),
    .rsp_evict_dirty(ev_dirty), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] res; logic [1:0] way; logic ev; logic [23:0] tag; logic d;
    logic [31:0] hc; logic [31:0] mc;
  } exp_t;
  exp_t sb[$];
  int acc_q[$];
  int checks = 0, errors = 0;
  bit hold_low = 0, rnd_bp = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // reference model: per-set ways plus a heap-ordered PLRU tree (node n, children 2n/2n+1)
  logic [23:0] m_tag[4][4];
  bit m_v[4][4], m_d[4][4], m_pt[4][4];
  int unsigned m_hc, m_mc;

  function automatic void model_reset();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 4; w++) begin
        m_v[s][w] = 0; m_d[s][w] = 0; m_pt[s][w] = 0; m_tag[s][w] = 0;
      end
    m_hc = 0; m_mc = 0;
  endfunction

  function automatic int m_victim(int s);
    int n = 1;
    for (int w = 0; w < 4; w++) if (!m_v[s][w]) return w;
    while (n < 4) n = 2 * n + int'(m_pt[s][n]);
    return n - 4;
  endfunction

  function automatic void m_touch(int s, int w);
    int n = w + 4;
    while (n > 1) begin
      m_pt[s][n / 2] = (n % 2 == 0);
      n = n / 2;
    end
  endfunction

  function automatic exp_t model(logic [31:0] a, logic [1:0] op);
    exp_t e = '{res: 0, way: 0, ev: 0, tag: 0, d: 0, hc: 0, mc: 0};
    int s = int'(a[7:6]);
    logic [23:0] t = a[31:8];
    int h = -1, v;
    for (int w = 0; w < 4; w++) if (m_v[s][w] && m_tag[s][w] == t) h = w;
    if (op == 2) begin
      if (h >= 0) begin
        e.res = 1; e.way = 2'(h); e.ev = 1; e.tag = t; e.d = m_d[s][h];
        m_v[s][h] = 0; m_d[s][h] = 0;
      end else e.res = 2;
    end else if (h >= 0) begin
      e.res = 1; e.way = 2'(h);
      if (op == 1) m_d[s][h] = 1;
      m_touch(s, h);
    end else begin
      v = m_victim(s);
      e.res = 2; e.way = 2'(v); e.ev = m_v[s][v];
      e.tag = m_v[s][v] ? m_tag[s][v] : 24'h0;
      e.d = m_v[s][v] && m_d[s][v];
      m_tag[s][v] = t; m_v[s][v] = 1; m_d[s][v] = (op == 1);
      m_touch(s, v);
    end
    if (e.res == 1) m_hc++; else m_mc++;
    e.hc = m_hc; e.mc = m_mc;
    return e;
  endfunction

  task automatic do_req(input logic [31:0] a, input logic [1:0] op);
    int n = 0;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin fail("req_ready_wait"); return; end
    req_valid = 1; req_addr = a; req_op = op;
    @(posedge clk);
    sb.push_back(model(a, op));
    #1 req_valid = 0; req_addr = $urandom; req_op = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    if (sb.size() != 0) fail("drain");
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) fail("rsp_valid_wait");
  endtask

  // consumer backpressure
  initial forever begin
    @(posedge clk); #1;
    rsp_ready = hold_low ? 1'b0 : rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // monitor: latency, hold stability and scoreboard comparison at each handshake
  exp_t e;
  bit in_rsp = 0;
  logic [1:0] s_res, s_way, last_res, last_way;
  logic s_ev, s_d, last_ev, last_d;
  logic [23:0] s_tag, last_tag;
  always @(negedge clk) begin
    if (rst) begin
      in_rsp = 0;
      acc_q.delete();
    end else begin
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1;
          s_res = rsp_result; s_way = rsp_way; s_ev = ev_valid; s_tag = ev_tag; s_d = ev_dirty;
          if (acc_q.size() == 0) fail("rsp_without_accept");
          else chk("latency", 64'(cyc - acc_q.pop_front()), 2);
        end else begin
          chk("hold_result", rsp_result, s_res);
          chk("hold_way", rsp_way, s_way);
          chk("hold_ev_valid", ev_valid, s_ev);
          chk("hold_ev_tag", ev_tag, s_tag);
          chk("hold_ev_dirty", ev_dirty, s_d);
          chk("ready_low_in_resp", req_ready, 0);
        end
        if (rsp_ready) begin
          in_rsp = 0;
          if (sb.size() == 0) fail("rsp_without_request");
          else begin
            e = sb.pop_front();
            chk("result", rsp_result, e.res);
            chk("way", rsp_way, e.way);
            chk("evict_valid", ev_valid, e.ev);
            chk("evict_tag", ev_tag, e.tag);
            chk("evict_dirty", ev_dirty, e.d);
            chk("hit_count", hit_count, e.hc);
            chk("miss_count", miss_count, e.mc);
            last_res = rsp_result; last_way = rsp_way; last_ev = ev_valid;
            last_tag = ev_tag; last_d = ev_dirty;
          end
        end
      end
    end
  end

  initial begin
    int n;
    logic [23:0] t;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    model_reset();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_hit_count", hit_count, 0);
    chk("reset_miss_count", miss_count, 0);
    n = 0;
    while (!req_ready && n < 20) begin n++; @(posedge clk); #1; end
    chk("init_cycles", n, 4);
    // first miss then hit on the same line
    do_req(32'h1000, 0);
    do_req(32'h1000, 0);
    drain();
    chk("dir_hits", hit_count, 1);
    chk("dir_misses", miss_count, 1);
    chk("dir_hit_result", last_res, 1);
    chk("dir_hit_way", last_way, 0);
    // fill set 0, touch way 0, then force a PLRU eviction
    do_req(32'h1000, 0); do_req(32'h1100, 0); do_req(32'h1200, 0);
    do_req(32'h1300, 0); do_req(32'h1000, 0); do_req(32'h1400, 0);
    drain();
    chk("plru_result", last_res, 2);
    chk("plru_way", last_way, 2);
    chk("plru_ev_valid", last_ev, 1);
    chk("plru_ev_tag", last_tag, 24'h12);
    chk("plru_ev_dirty", last_d, 0);
    // write then invalidate twice
    do_req(32'h2000, 1);
    do_req(32'h2000, 2);
    drain();
    chk("inv_result", last_res, 1);
    chk("inv_ev_tag", last_tag, 24'h20);
    chk("inv_ev_dirty", last_d, 1);
    do_req(32'h2000, 2);
    drain();
    chk("inv2_result", last_res, 2);
    chk("inv2_ev_valid", last_ev, 0);
    // hold the response under backpressure
    hold_low = 1;
    do_req(32'h1400, 0);
    wait_rsp();
    repeat (5) begin @(posedge clk); #1; chk("bp_rsp_held", rsp_valid, 1); end
    hold_low = 0;
    drain();
    // randomized traffic over a small tag pool to exercise hits, fills and evictions
    rnd_bp = 1;
    for (int i = 0; i < 300; i++) begin
      t = 24'($urandom_range(16, 23));
      a = {t, 2'($urandom_range(0, 3)), 6'($urandom)};
      do_req(a, 2'($urandom_range(0, 3)));
    end
    drain();
    rnd_bp = 0;
    chk("final_hits", hit_count, m_hc);
    chk("final_misses", miss_count, m_mc);
    // reset while a response is pending
    hold_low = 1;
    do_req(32'h3040, 1);
    wait_rsp();
    @(posedge clk); #1 rst = 1;
    sb.delete();
    @(posedge clk); #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);
    rst = 0;
    model_reset();
    hold_low = 0;
    do_req(32'h3040, 0);
    drain();
    chk("post_rst_result", last_res, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
